// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data-memory controller:
//   - default widths and depth used by the interface and the modules
//   - clearState_e : the clear-engine state encoding
//   - phase_ok()   : decides whether an access may be honoured this cycle
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int DEF_DW    = 8;    // data word width
    localparam int DEF_AW    = 8;    // address width
    localparam int DEF_DEPTH = 256;  // implemented words
    localparam int DEF_PCW   = 13;   // program counter width

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clearState_e;

    // With the gate enabled, only odd-PC cycles carry a data access; with it
    // disabled every cycle may access the memory.
    function automatic logic phase_ok(input logic pcLsb, input bit gate);
        return gate ? pcLsb : 1'b1;
    endfunction

endpackage : data_mem_pkg

// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Data-memory port between the datapath (master) and the controller (slave).
//   Requests  (master -> slave): DataAddress, ReadMem, WriteMem, DataIn, PC,
//                                ClearReq
//   Responses (slave -> master): DataOut, DataValid, Busy, AddrErr
// -----------------------------------------------------------------------------
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int PCW = DEF_PCW
) ();

    logic [AW-1:0]  DataAddress;
    logic           ReadMem;
    logic           WriteMem;
    logic [DW-1:0]  DataIn;
    logic [PCW-1:0] PC;
    logic           ClearReq;

    logic [DW-1:0]  DataOut;
    logic           DataValid;
    logic           Busy;
    logic           AddrErr;

    modport master (
        output DataAddress, ReadMem, WriteMem, DataIn, PC, ClearReq,
        input  DataOut, DataValid, Busy, AddrErr
    );

    modport slave (
        input  DataAddress, ReadMem, WriteMem, DataIn, PC, ClearReq,
        output DataOut, DataValid, Busy, AddrErr
    );

endinterface : data_mem_if

// File: rtl/mem_clear_fsm.sv
// -----------------------------------------------------------------------------
// mem_clear_fsm
// Zero-fill engine for the data array. Walks clrAddr from 0 to DEPTH-1, one
// word per cycle, raising Busy for exactly DEPTH cycles.
//   CLK      in   system clock
//   Reset_n  in   synchronous active-low reset
//   ClearReq in   one-cycle pulse; starts a clear when idle, ignored otherwise
//   Busy     out  registered; high while the clear is running
//   clrWe    out  clear write enable (write zero to clrAddr this cycle)
//   clrAddr  out  clear write address, AW+1 bits so DEPTH itself is reachable
// -----------------------------------------------------------------------------
module mem_clear_fsm
    import data_mem_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DEPTH          = DEF_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        ClearReq,
    output logic        Busy,
    output logic        clrWe,
    output logic [AW:0] clrAddr
);

    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    clearState_e state;

    // NOTE: non-blocking assignments throughout, so every register here
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            // A reset in the middle of a clear either restarts it from word 0
            // or abandons it, leaving the array partially cleared.
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            Busy    <= CLEAR_ON_RESET;
            clrAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ClearReq) begin
                        state   <= CLEAR;
                        Busy    <= 1'b1;
                        clrAddr <= '0;
                    end
                end
                CLEAR: begin
                    // ClearReq is not looked at here: a running clear is never
                    // restarted.
                    clrAddr <= clrAddr + 1'b1;
                    if (clrAddr == LAST_ADDR) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Busy mirrors state==CLEAR exactly, so it doubles as the write strobe.
    assign clrWe = Busy;

endmodule : mem_clear_fsm

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Synchronous-write data RAM on the datapath's data-memory port, with an
// optional PC-phase access gate, a zero-fill clear engine and status outputs.
//   CLK      in   system clock, all state on the rising edge
//   Reset_n  in   synchronous active-low reset
//   bus      slave side of data_mem_if:
//     DataAddress/ReadMem/WriteMem/DataIn  access request
//     PC        program counter (bit 0 selects the access phase)
//     ClearReq  one-cycle pulse starting a zero-fill
//     DataOut   read data, 0 whenever DataValid=0
//     DataValid DataOut carries a read result
//     Busy      clear running; all accesses ignored
//     AddrErr   one-cycle pulse: previous accepted access was out of range
// READ_LAT=0 gives a combinational read in the request cycle; READ_LAT=1
// registers it into the following cycle. Both return the pre-write value when
// reading and writing the same word in one cycle.
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DW             = DEF_DW,
    parameter int AW             = DEF_AW,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int PCW            = DEF_PCW,
    parameter int READ_LAT       = 0,
    parameter bit PHASE_GATE     = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic      CLK,
    input  logic      Reset_n,
    data_mem_if.slave bus
);

    // Compare in AW+1 bits so DEPTH == 2**AW is representable.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] core [DEPTH];

    logic          busy;
    logic          clrWe;
    logic [AW:0]   clrAddr;
    logic          phaseOk;
    logic          rdEn;
    logic          wrEn;
    logic          inRange;
    logic [PCW-1:0] pcLocal;
    logic          unusedBits;

    // ------------------------------------------------------------------ clear
    mem_clear_fsm #(
        .AW             (AW),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .ClearReq (bus.ClearReq),
        .Busy     (busy),
        .clrWe    (clrWe),
        .clrAddr  (clrAddr)
    );

    assign bus.Busy = busy;

    // ---------------------------------------------------------------- enables
    assign pcLocal = bus.PC;
    assign phaseOk = phase_ok(pcLocal[0], PHASE_GATE);
    assign rdEn    = bus.ReadMem  & phaseOk & ~busy;
    assign wrEn    = bus.WriteMem & phaseOk & ~busy;
    assign inRange = {1'b0, bus.DataAddress} < DEPTH_W;

    // Only PC[0] matters, and clrAddr never exceeds DEPTH-1 while writing.
    assign unusedBits = ^{pcLocal[PCW-1:1], clrAddr[AW]};

    // ------------------------------------------------------------ write port
    // NOTE: the array has no reset branch; zeroing it is the clear engine's
    // job, which keeps the storage mappable onto plain RAM.
    always_ff @(posedge CLK) begin
        if (Reset_n) begin
            // User writes cannot coincide with clear writes (Busy blocks
            // them), so this priority only fixes the mux structure.
            if (clrWe) begin
                core[clrAddr[AW-1:0]] <= '0;
            end else if (wrEn && inRange) begin
                core[bus.DataAddress] <= bus.DataIn;
            end
        end
    end

    // -------------------------------------------------------------- AddrErr
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            bus.AddrErr <= 1'b0;
        end else begin
            bus.AddrErr <= (rdEn | wrEn) & ~inRange;
        end
    end

    // ------------------------------------------------------------ read path
    generate
        if (READ_LAT == 0) begin : g_read_comb
            // NOTE: every output gets a default before any condition, so no
            // path through the block leaves it unassigned (no latch).
            always_comb begin
                bus.DataOut   = '0;
                bus.DataValid = 1'b0;
                if (rdEn && inRange) begin
                    bus.DataOut   = core[bus.DataAddress];
                    bus.DataValid = 1'b1;
                end
            end
        end else begin : g_read_reg
            // The array is read at the same edge that may write it, so the
            // registered value is the pre-write word. An out-of-range read
            // still completes, with zero data.
            always_ff @(posedge CLK) begin
                if (!Reset_n) begin
                    bus.DataOut   <= '0;
                    bus.DataValid <= 1'b0;
                end else begin
                    bus.DataValid <= rdEn;
                    bus.DataOut   <= (rdEn && inRange) ? core[bus.DataAddress] : '0;
                end
            end
        end
    endgenerate

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
// Four controllers share one stimulus stream:
//   A: defaults (READ_LAT=0, PHASE_GATE=1, DEPTH=256, clear on reset)
//   B: READ_LAT=1
//   C: PHASE_GATE=0
//   D: READ_LAT=1, DEPTH=200, no clear on reset
// Expected read/error results are queued when a request is driven and
// compared at the cycle each controller should present them.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [7:0]  addr;
    logic        rd, wr, clrReq;
    logic [7:0]  din;
    logic [12:0] pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    data_mem_if busA ();
    data_mem_if busB ();
    data_mem_if busC ();
    data_mem_if busD ();

    assign busA.DataAddress = addr; assign busA.ReadMem = rd; assign busA.WriteMem = wr;
    assign busA.DataIn = din;       assign busA.PC = pc;      assign busA.ClearReq = clrReq;
    assign busB.DataAddress = addr; assign busB.ReadMem = rd; assign busB.WriteMem = wr;
    assign busB.DataIn = din;       assign busB.PC = pc;      assign busB.ClearReq = clrReq;
    assign busC.DataAddress = addr; assign busC.ReadMem = rd; assign busC.WriteMem = wr;
    assign busC.DataIn = din;       assign busC.PC = pc;      assign busC.ClearReq = clrReq;
    assign busD.DataAddress = addr; assign busD.ReadMem = rd; assign busD.WriteMem = wr;
    assign busD.DataIn = din;       assign busD.PC = pc;      assign busD.ClearReq = clrReq;

    data_mem_ctrl #(.READ_LAT(0), .PHASE_GATE(1'b1), .DEPTH(256), .CLEAR_ON_RESET(1'b1))
        dutA (.CLK(CLK), .Reset_n(Reset_n), .bus(busA));
    data_mem_ctrl #(.READ_LAT(1), .PHASE_GATE(1'b1), .DEPTH(256), .CLEAR_ON_RESET(1'b1))
        dutB (.CLK(CLK), .Reset_n(Reset_n), .bus(busB));
    data_mem_ctrl #(.READ_LAT(0), .PHASE_GATE(1'b0), .DEPTH(256), .CLEAR_ON_RESET(1'b1))
        dutC (.CLK(CLK), .Reset_n(Reset_n), .bus(busC));
    data_mem_ctrl #(.READ_LAT(1), .PHASE_GATE(1'b1), .DEPTH(200), .CLEAR_ON_RESET(1'b0))
        dutD (.CLK(CLK), .Reset_n(Reset_n), .bus(busD));

    logic [7:0] dOut [4];
    logic       dV [4];
    logic       dE [4];
    logic       dB [4];
    string      dn [4] = '{"A", "B", "C", "D"};

    assign dOut[0] = busA.DataOut; assign dV[0] = busA.DataValid; assign dE[0] = busA.AddrErr; assign dB[0] = busA.Busy;
    assign dOut[1] = busB.DataOut; assign dV[1] = busB.DataValid; assign dE[1] = busB.AddrErr; assign dB[1] = busB.Busy;
    assign dOut[2] = busC.DataOut; assign dV[2] = busC.DataValid; assign dE[2] = busC.AddrErr; assign dB[2] = busC.Busy;
    assign dOut[3] = busD.DataOut; assign dV[3] = busD.DataValid; assign dE[3] = busD.AddrErr; assign dB[3] = busD.Busy;

    function automatic int latOf(input int i);
        return (i == 1 || i == 3) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        int         due;
        int         dut;
        string      name;
        bit         chkData;
        logic [7:0] d;
        logic       v;
        bit         chkErr;
        logic       e;
    } sbEntry_t;

    sbEntry_t sbq[$];

    always @(negedge CLK) begin
        sbEntry_t keep[$];
        keep.delete();
        foreach (sbq[k]) begin
            if (sbq[k].due == cyc) begin
                if (sbq[k].chkData) begin
                    check({sbq[k].name, "/", dn[sbq[k].dut], "/DataOut"},   32'(dOut[sbq[k].dut]), 32'(sbq[k].d));
                    check({sbq[k].name, "/", dn[sbq[k].dut], "/DataValid"}, 32'(dV[sbq[k].dut]),   32'(sbq[k].v));
                end
                if (sbq[k].chkErr)
                    check({sbq[k].name, "/", dn[sbq[k].dut], "/AddrErr"},   32'(dE[sbq[k].dut]),   32'(sbq[k].e));
            end else begin
                keep.push_back(sbq[k]);
            end
        end
        sbq = keep;
    end

    // Drive one request cycle and queue the expected response of each DUT
    // selected in chk (bit i = DUT i; expD byte i = DUT i).
    task automatic drive(input string name, input logic [7:0] a, input logic r, input logic w,
                         input logic [7:0] di, input logic [12:0] p, input logic cr,
                         input logic [3:0] chk, input logic [31:0] expD,
                         input logic [3:0] expV, input logic [3:0] expE);
        sbEntry_t en;
        addr = a; rd = r; wr = w; din = di; pc = p; clrReq = cr;
        for (int i = 0; i < 4; i++) begin
            if (chk[i]) begin
                en.dut = i; en.name = name;
                en.d = expD[i*8 +: 8]; en.v = expV[i]; en.e = expE[i];
                if (latOf(i) == 0) begin
                    en.due = cyc;     en.chkData = 1'b1; en.chkErr = 1'b0; sbq.push_back(en);
                    en.due = cyc + 1; en.chkData = 1'b0; en.chkErr = 1'b1; sbq.push_back(en);
                end else begin
                    en.due = cyc + 1; en.chkData = 1'b1; en.chkErr = 1'b1; sbq.push_back(en);
                end
            end
        end
        @(posedge CLK); #1;
    endtask

    // Count Busy cycles of A/B/C until all three drop, bounded to 400 cycles.
    // A ClearReq pulse is issued on iteration pulseAt (negative: none).
    task automatic countBusy(input int pulseAt, output int nA, output int nB, output int nC);
        bit done;
        nA = 0; nB = 0; nC = 0;
        rd = 1'b0; wr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            clrReq = (i == pulseAt);
            @(negedge CLK);
            if (dB[0]) nA++;
            if (dB[1]) nB++;
            if (dB[2]) nC++;
            done = !dB[0] && !dB[1] && !dB[2];
            @(posedge CLK); #1;
            if (done) break;
        end
        clrReq = 1'b0;
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        string       name;
        logic [7:0]  a;
        logic        r;
        logic        w;
        logic [7:0]  di;
        logic [12:0] p;
        logic [3:0]  chk;
        logic [31:0] d;
        logic [3:0]  v;
        logic [3:0]  e;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  nA, nB, nC;
        bit  dIdle;

        vecs.push_back('{"wr10",      8'h10, 1'b0, 1'b1, 8'hA5, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"rd10",      8'h10, 1'b1, 1'b0, 8'h00, 13'd7,     4'hF, 32'hA5A5A5A5, 4'hF, 4'h0});
        vecs.push_back('{"wr20even",  8'h20, 1'b0, 1'b1, 8'h3C, 13'd4,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"rd20",      8'h20, 1'b1, 1'b0, 8'h00, 13'd5,     4'h7, 32'h003C0000, 4'h7, 4'h0});
        vecs.push_back('{"wr30old",   8'h30, 1'b0, 1'b1, 8'h11, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"rdwr30",    8'h30, 1'b1, 1'b1, 8'h22, 13'd5,     4'hF, 32'h11111111, 4'hF, 4'h0});
        vecs.push_back('{"rd30new",   8'h30, 1'b1, 1'b0, 8'h00, 13'd5,     4'hF, 32'h22222222, 4'hF, 4'h0});
        vecs.push_back('{"wrF0",      8'hF0, 1'b0, 1'b1, 8'h77, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h8});
        vecs.push_back('{"rdF0",      8'hF0, 1'b1, 1'b0, 8'h00, 13'd5,     4'hF, 32'h00777777, 4'hF, 4'h8});
        vecs.push_back('{"rdF0even",  8'hF0, 1'b1, 1'b0, 8'h00, 13'd4,     4'hF, 32'h00770000, 4'h4, 4'h0});
        vecs.push_back('{"idle",      8'h00, 1'b0, 1'b0, 8'h00, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"wrC7",      8'hC7, 1'b0, 1'b1, 8'h5A, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"rdC7",      8'hC7, 1'b1, 1'b0, 8'h00, 13'd5,     4'hF, 32'h5A5A5A5A, 4'hF, 4'h0});
        vecs.push_back('{"rdC8",      8'hC8, 1'b1, 1'b0, 8'h00, 13'd5,     4'hF, 32'h00000000, 4'hF, 4'h8});
        vecs.push_back('{"rdFF",      8'hFF, 1'b1, 1'b0, 8'h00, 13'd5,     4'hF, 32'h00000000, 4'hF, 4'h8});
        vecs.push_back('{"idle2",     8'h00, 1'b0, 1'b0, 8'h00, 13'd5,     4'hF, 32'h00000000, 4'h0, 4'h0});
        vecs.push_back('{"rd10hiPC",  8'h10, 1'b1, 1'b0, 8'h00, 13'h1FF5,  4'hF, 32'hA5A5A5A5, 4'hF, 4'h0});

        addr = '0; rd = 1'b0; wr = 1'b0; din = '0; pc = '0; clrReq = 1'b0;
        Reset_n = 1'b0;

        // Reset values.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            check({"rst/", dn[i], "/DataOut"},   32'(dOut[i]), 32'h0);
            check({"rst/", dn[i], "/DataValid"}, 32'(dV[i]),   32'h0);
            check({"rst/", dn[i], "/AddrErr"},   32'(dE[i]),   32'h0);
            check({"rst/", dn[i], "/Busy"},      32'(dB[i]),   (i == 3) ? 32'h0 : 32'h1);
        end
        @(posedge CLK); #1;
        Reset_n = 1'b1;

        // Clear after reset lasts exactly DEPTH cycles.
        countBusy(-1, nA, nB, nC);
        check("initClear/A/busyCycles", 32'(nA), 32'd256);
        check("initClear/B/busyCycles", 32'(nB), 32'd256);
        check("initClear/C/busyCycles", 32'(nC), 32'd256);

        // Every word reads zero; D reports out-of-range above 199.
        for (int a = 0; a < 256; a++) begin
            drive("rdAll", 8'(a), 1'b1, 1'b0, 8'h00, 13'd1, 1'b0,
                  (a >= 200) ? 4'hF : 4'h7, 32'h0, (a >= 200) ? 4'hF : 4'h7,
                  (a >= 200) ? 4'h8 : 4'h0);
        end

        foreach (vecs[k])
            drive(vecs[k].name, vecs[k].a, vecs[k].r, vecs[k].w, vecs[k].di, vecs[k].p, 1'b0,
                  vecs[k].chk, vecs[k].d, vecs[k].v, vecs[k].e);

        // Fill 0x40..0x4F, then ClearReq together with a read of 0x40: the
        // read is still serviced with pre-clear data.
        for (int a = 8'h40; a <= 8'h4F; a++)
            drive("fill", 8'(a), 1'b0, 1'b1, 8'hFF, 13'd5, 1'b0, 4'h0, 32'h0, 4'h0, 4'h0);
        drive("clrRd40", 8'h40, 1'b1, 1'b0, 8'h00, 13'd5, 1'b1, 4'hF, 32'hFFFFFFFF, 4'hF, 4'h0);
        clrReq = 1'b0; rd = 1'b0;

        for (int i = 0; i < 99; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                check("clrStart/A/Busy", 32'(dB[0]), 32'h1);
                check("clrStart/D/Busy", 32'(dB[3]), 32'h1);
            end
            @(posedge CLK); #1;
        end

        // Reset during clear cycle 100.
        Reset_n = 1'b0;
        @(negedge CLK);
        check("preReset/A/Busy", 32'(dB[0]), 32'h1);
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        @(negedge CLK);
        check("midReset/A/Busy", 32'(dB[0]), 32'h1);
        check("midReset/D/Busy", 32'(dB[3]), 32'h0);
        @(posedge CLK); #1;

        // Restarted clear: a ClearReq pulse inside it must not restart it.
        countBusy(9, nA, nB, nC);
        check("restart/A/busyCycles", 32'(nA + 1), 32'd256);
        check("restart/B/busyCycles", 32'(nB + 1), 32'd256);
        check("restart/C/busyCycles", 32'(nC + 1), 32'd256);

        // D was idle and took that pulse as a real clear; wait for it.
        dIdle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            dIdle = !dB[3];
            @(posedge CLK); #1;
            if (dIdle) break;
        end
        check("D/clearDone", 32'(dIdle), 32'h1);

        for (int a = 8'h40; a <= 8'h4F; a++)
            drive("rdCleared", 8'(a), 1'b1, 1'b0, 8'h00, 13'd5, 1'b0, 4'hF, 32'h0, 4'hF, 4'h0);

        drive("drain", 8'h00, 1'b0, 1'b0, 8'h00, 13'd5, 1'b0, 4'h0, 32'h0, 4'h0, 4'h0);
        drive("drain", 8'h00, 1'b0, 1'b0, 8'h00, 13'd5, 1'b0, 4'h0, 32'h0, 4'h0, 4'h0);
        check("scoreboardDrained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_data_mem_ctrl

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised successor to the single-port data memory: a synchronous-write data RAM with configurable width, depth and read latency. Also provides an optional PC-phase access gate, a hardware clear engine that zero-fills the array after reset or on request, and valid/busy/error status. It sits on the datapath's data-memory port, addressed by the ALU result and fed from the register file.

Parameters:
DW, 8, data word width in bits
AW, 8, address width in bits
DEPTH, 256, number of words implemented (DEPTH <= 2**AW)
PCW, 13, program counter width
READ_LAT, 0, read latency: 0 = combinational, 1 = registered
PHASE_GATE, 1, 1 = accesses honoured only when PC[0]==1; 0 = every cycle
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = contents undefined after reset

Ports:
CLK  in  1  system clock, all state on rising edge
Reset_n  in  1  reset; one clock; reset is synchronous and active-low
DataAddress  in  AW  word address for read and write
ReadMem  in  1  read request
WriteMem  in  1  write request
DataIn  in  DW  write data
PC  in  PCW  program counter, used for phase gating
ClearReq  in  1  one-cycle pulse that starts a zero-fill
DataOut  out  DW  read data; 0 when DataValid=0
DataValid  out  1  DataOut holds a valid read result
Busy  out  1  clear engine active; all accesses are ignored
AddrErr  out  1  registered one-cycle pulse: the previous accepted access was out of range

Behaviour:
- Access enables:
  - phase_ok = PHASE_GATE ? PC[0] : 1.
  - rd_en = ReadMem & phase_ok & ~Busy.
  - wr_en = WriteMem & phase_ok & ~Busy.
  - in_range = DataAddress < DEPTH.
- Writes: at the rising edge, when wr_en & in_range, core[DataAddress] <= DataIn. When wr_en & ~in_range, the write is dropped.
- READ_LAT=0:
  - DataOut = core[DataAddress] and DataValid=1 in the same cycle, when rd_en & in_range.
  - Otherwise DataOut=0 and DataValid=0. No tristate.
- READ_LAT=1:
  - The read is sampled at the edge; DataOut and DataValid are registered and appear in the next cycle, for exactly one cycle unless re-read.
  - Out-of-range read: DataOut=0 and DataValid=1. In range read: core data.
- Simultaneous read and write to the same address: read-before-write; the read returns the old value in both latency modes.
- AddrErr: registered; asserted the cycle after any (rd_en|wr_en) with ~in_range.
- FSM states: CLEAR, IDLE. Counter clr_addr is AW+1 bits wide.
  - Reset (Reset_n=0 at edge): state <= CLEAR if CLEAR_ON_RESET, else IDLE. clr_addr <= 0. DataOut register, DataValid and AddrErr <= 0.
  - CLEAR: each cycle core[clr_addr] <= 0 and clr_addr++. When clr_addr == DEPTH-1 is written, go to IDLE. Total duration is DEPTH cycles. Busy=1 throughout.
  - IDLE: Busy=0. ClearReq=1 -> CLEAR with clr_addr <= 0; ReadMem/WriteMem in that same cycle are still serviced.
  - ClearReq while in CLEAR: ignored; the clear is not restarted.
- Reset mid-clear: the clear restarts from address 0 (CLEAR_ON_RESET=1), or is abandoned (CLEAR_ON_RESET=0), with contents partially cleared.
- Reset values: DataOut=0, DataValid=0, AddrErr=0. Busy = CLEAR_ON_RESET in the first cycle after reset.
- A registered read in flight when ClearReq is accepted still completes in the next cycle with the pre-clear data.

Decomposition:
- Package data_mem_pkg:
  - state enum {IDLE, CLEAR}
  - default-width localparams
  - helper function phase_ok(pc, gate)
- One natural sub-module: mem_clear_fsm. It holds the state register, clr_addr and Busy, and outputs the clear write port (clr_we, clr_addr).
- The top level holds the array, the write-port mux (clear vs. user), the read path and AddrErr.

Test Plan:
- Reset, default params -> Busy=1 for exactly 256 cycles, then 0. Every address subsequently reads 0.
- PC=5, WriteMem, addr 0x10, DataIn 0xA5, then PC=7 ReadMem addr 0x10 -> DataOut=0xA5, DataValid=1 (same cycle at READ_LAT=0; next cycle at READ_LAT=1).
- PC=4 (even), WriteMem addr 0x20 data 0x3C, then odd-PC read -> 0x00. With PHASE_GATE=0 the same sequence returns 0x3C.
- READ_LAT=1, same cycle read+write addr 0x30: old 0x11, new 0x22 -> DataOut=0x11 next cycle; a following read returns 0x22.
- DEPTH=200, write addr 0xF0 with 0x77 -> AddrErr pulse 1 cycle, no array change. A read of 0xF0 -> DataOut=0, AddrErr=1.
- ClearReq after filling 0x40..0x4F with 0xFF; Reset_n low for 1 cycle at clear cycle 100 -> clear restarts, Busy high 256 more cycles, then 0x40..0x4F read 0.
